// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 raster timing source.
// Registered DrawX/DrawY with aligned blank/hs/vs decode, PIPE_DELAY-cycle
// delayed sync/blank copies for pipelined pixel mappers, line/frame pulses
// and a completed-frame counter.
// Optional macro VGA_TEST_PATTERN_EN adds an 8-bar colour test pattern on
// pat_red/pat_green/pat_blue, aligned with one cycle of pipeline delay.
//
// state | meaning
// IDLE  | held in reset; first released edge presents the (0,0) decode
// RUN   | counters advance every edge, outputs decode the new position
module vga_timing_gen #(
   parameter int H_VISIBLE  = 640,
   parameter int H_FRONT    = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BACK     = 48,
   parameter int V_VISIBLE  = 480,
   parameter int V_FRONT    = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BACK     = 33,
   parameter int PIPE_DELAY = 2
) (
   input  logic        vga_clk,
   input  logic        reset_n,
   output logic [9:0]  DrawX,
   output logic [9:0]  DrawY,
   output logic        blank,
   output logic        hs,
   output logic        vs,
   output logic        hs_d,
   output logic        vs_d,
   output logic        blank_d,
   output logic        line_start,
   output logic        frame_start,
`ifdef VGA_TEST_PATTERN_EN
   output logic [15:0] frame_count,
   output logic [3:0]  pat_red,
   output logic [3:0]  pat_green,
   output logic [3:0]  pat_blue
`else
   output logic [15:0] frame_count
`endif
);

   localparam logic [9:0] H_MAX    = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
   localparam logic [9:0] V_MAX    = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
   localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
   localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
   localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
   localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t      r_state;
   logic [9:0]  r_x, r_y;
   logic        r_blank, r_hs, r_vs, r_line_start, r_frame_start;
   logic [15:0] r_frame_count;

   logic [9:0]  w_x_nxt, w_y_nxt;
   logic        w_frame_wrap;
   logic        w_blank_nxt, w_hs_nxt, w_vs_nxt;

   // Next raster position; IDLE holds (0,0) so the first released edge shows it.
   always_comb begin
      w_x_nxt      = r_x;
      w_y_nxt      = r_y;
      w_frame_wrap = 1'b0;
      if (r_state == S_RUN) begin
         if (r_x == H_MAX) begin
            w_x_nxt = '0;
            if (r_y == V_MAX) begin
               w_y_nxt      = '0;
               w_frame_wrap = 1'b1;
            end else begin
               w_y_nxt = r_y + 10'd1;
            end
         end else begin
            w_x_nxt = r_x + 10'd1;
         end
      end
   end

   // Decode of the next position, registered alongside the counters.
   always_comb begin
      w_blank_nxt = (w_x_nxt < H_VIS) && (w_y_nxt < V_VIS);
      w_hs_nxt    = !((w_x_nxt >= HS_START) && (w_x_nxt <= HS_END));
      w_vs_nxt    = !((w_y_nxt >= VS_START) && (w_y_nxt <= VS_END));
   end

   // Sequencer: counters, aligned decode and frame counter.
   always_ff @(posedge vga_clk) begin
      if (!reset_n) begin
         r_state       <= S_IDLE;
         r_x           <= '0;
         r_y           <= '0;
         r_blank       <= 1'b0;
         r_hs          <= 1'b1;
         r_vs          <= 1'b1;
         r_line_start  <= 1'b0;
         r_frame_start <= 1'b0;
         r_frame_count <= '0;
      end else begin
         r_state       <= S_RUN;
         r_x           <= w_x_nxt;
         r_y           <= w_y_nxt;
         r_blank       <= w_blank_nxt;
         r_hs          <= w_hs_nxt;
         r_vs          <= w_vs_nxt;
         r_line_start  <= (w_x_nxt == '0);
         r_frame_start <= (w_x_nxt == '0) && (w_y_nxt == '0);
         if (w_frame_wrap) begin
            r_frame_count <= r_frame_count + 16'd1;
         end
      end
   end

   assign DrawX       = r_x;
   assign DrawY       = r_y;
   assign blank       = r_blank;
   assign hs          = r_hs;
   assign vs          = r_vs;
   assign line_start  = r_line_start;
   assign frame_start = r_frame_start;
   assign frame_count = r_frame_count;

   generate
      if (PIPE_DELAY == 0) begin : g_nodly
         assign hs_d    = r_hs;
         assign vs_d    = r_vs;
         assign blank_d = r_blank;
      end else begin : g_dly
         logic [PIPE_DELAY-1:0] r_hs_sr, r_vs_sr, r_blank_sr;

         // Delay line; cleared only by reset so wraps never disturb it.
         always_ff @(posedge vga_clk) begin
            if (!reset_n) begin
               r_hs_sr    <= '1;
               r_vs_sr    <= '1;
               r_blank_sr <= '0;
            end else begin
               r_hs_sr[0]    <= r_hs;
               r_vs_sr[0]    <= r_vs;
               r_blank_sr[0] <= r_blank;
               for (int i = 1; i < PIPE_DELAY; i++) begin
                  r_hs_sr[i]    <= r_hs_sr[i-1];
                  r_vs_sr[i]    <= r_vs_sr[i-1];
                  r_blank_sr[i] <= r_blank_sr[i-1];
               end
            end
         end

         assign hs_d    = r_hs_sr[PIPE_DELAY-1];
         assign vs_d    = r_vs_sr[PIPE_DELAY-1];
         assign blank_d = r_blank_sr[PIPE_DELAY-1];
      end
   endgenerate

`ifdef VGA_TEST_PATTERN_EN
   logic [9:0] w_bar;
   logic [2:0] w_rgb;
   logic [3:0] r_pat_r, r_pat_g, r_pat_b;

   // Bar colour from the 80-pixel column index: bit2=R, bit1=G, bit0=B.
   always_comb begin
      w_bar = r_x / 10'd80;
      case (w_bar)
         10'd0:   w_rgb = 3'b111;
         10'd1:   w_rgb = 3'b110;
         10'd2:   w_rgb = 3'b011;
         10'd3:   w_rgb = 3'b010;
         10'd4:   w_rgb = 3'b101;
         10'd5:   w_rgb = 3'b100;
         10'd6:   w_rgb = 3'b001;
         default: w_rgb = 3'b000;
      endcase
   end

   // Pattern register; gating with current blank equals the 1-cycle delayed blank.
   always_ff @(posedge vga_clk) begin
      if (!reset_n) begin
         r_pat_r <= '0;
         r_pat_g <= '0;
         r_pat_b <= '0;
      end else begin
         r_pat_r <= {4{w_rgb[2] & r_blank}};
         r_pat_g <= {4{w_rgb[1] & r_blank}};
         r_pat_b <= {4{w_rgb[0] & r_blank}};
      end
   end

   assign pat_red   = r_pat_r;
   assign pat_green = r_pat_g;
   assign pat_blue  = r_pat_b;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (default 640x480 with delay 2,
// short-frame with delay 0, tiny raster with delay 1) checked every cycle
// against a cycle-count arithmetic model, plus hand-computed spot checks.
module tb_vga_timing_gen;

   logic vga_clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 vga_clk = ~vga_clk;

   logic [9:0]  a_dx[3], a_dy[3];
   logic        a_bl[3], a_hs[3], a_vs[3], a_hsd[3], a_vsd[3], a_bld[3], a_ls[3], a_fs[3];
   logic [15:0] a_fc[3];

   vga_timing_gen #(.PIPE_DELAY(2)) dut0 (
      .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(a_dx[0]), .DrawY(a_dy[0]),
      .blank(a_bl[0]), .hs(a_hs[0]), .vs(a_vs[0]), .hs_d(a_hsd[0]), .vs_d(a_vsd[0]),
      .blank_d(a_bld[0]), .line_start(a_ls[0]), .frame_start(a_fs[0]), .frame_count(a_fc[0]));

   vga_timing_gen #(.V_VISIBLE(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .PIPE_DELAY(0)) dut1 (
      .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(a_dx[1]), .DrawY(a_dy[1]),
      .blank(a_bl[1]), .hs(a_hs[1]), .vs(a_vs[1]), .hs_d(a_hsd[1]), .vs_d(a_vsd[1]),
      .blank_d(a_bld[1]), .line_start(a_ls[1]), .frame_start(a_fs[1]), .frame_count(a_fc[1]));

   vga_timing_gen #(.H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
                    .V_VISIBLE(2), .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .PIPE_DELAY(1)) dut2 (
      .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(a_dx[2]), .DrawY(a_dy[2]),
      .blank(a_bl[2]), .hs(a_hs[2]), .vs(a_vs[2]), .hs_d(a_hsd[2]), .vs_d(a_vsd[2]),
      .blank_d(a_bld[2]), .line_start(a_ls[2]), .frame_start(a_fs[2]), .frame_count(a_fc[2]));

   int g_hv[3] = '{640, 640, 4};
   int g_hf[3] = '{16, 16, 1};
   int g_hw[3] = '{96, 96, 2};
   int g_hb[3] = '{48, 48, 1};
   int g_vv[3] = '{480, 12, 2};
   int g_vf[3] = '{10, 2, 1};
   int g_vw[3] = '{2, 2, 1};
   int g_vb[3] = '{33, 3, 1};
   int g_pd[3] = '{2, 0, 1};

   // Model: cycles since reset release (-1 while in reset), frame-count offset,
   // and history of undelayed {hs,vs,blank}, index 0 = current cycle.
   longint     t[3] = '{-1, -1, -1};
   int         fcoff[3] = '{0, 0, 0};
   logic [2:0] hist[3][4];
   bit         started = 1'b0;

   int n_vec  = 0;
   int n_fail = 0;

   // Packing: x[43:34] y[33:24] blank hs vs hs_d vs_d blank_d line_start frame_start fc[15:0]
   function automatic logic [43:0] expv(int k);
      longint tt, pos, fr;
      int ht, x, y;
      logic b, h, v, l, f;
      logic [15:0] c;
      logic [2:0] dl;
      tt = t[k];
      ht = g_hv[k] + g_hf[k] + g_hw[k] + g_hb[k];
      fr = longint'(ht) * longint'(g_vv[k] + g_vf[k] + g_vw[k] + g_vb[k]);
      if (tt < 0) begin
         x = 0; y = 0; b = 1'b0; h = 1'b1; v = 1'b1; l = 1'b0; f = 1'b0; c = '0;
      end else begin
         pos = tt % fr;
         x = int'(pos % ht);
         y = int'(pos / ht);
         b = (x < g_vv[k] * 0 + g_hv[k]) && (y < g_vv[k]);
         h = !(x >= g_hv[k] + g_hf[k] && x < g_hv[k] + g_hf[k] + g_hw[k]);
         v = !(y >= g_vv[k] + g_vf[k] && y < g_vv[k] + g_vf[k] + g_vw[k]);
         l = (x == 0);
         f = (pos == 0);
         c = 16'(fcoff[k] + int'(tt / fr));
      end
      dl = hist[k][g_pd[k]];
      return {10'(x), 10'(y), b, h, v, dl[2], dl[1], dl[0], l, f, c};
   endfunction

   // Model advance on each active edge.
   always @(posedge vga_clk) begin
      logic [43:0] e;
      if (!reset_n) started = 1'b1;
      for (int k = 0; k < 3; k++) begin
         if (!reset_n) begin
            t[k] = -1;
            fcoff[k] = 0;
         end else begin
            t[k] = t[k] + 1;
         end
         e = expv(k);
         for (int i = 3; i > 0; i--) hist[k][i] = hist[k][i-1];
         hist[k][0] = {e[22], e[21], e[23]};
         if (!reset_n) for (int i = 0; i < 4; i++) hist[k][i] = 3'b110;
      end
   end

   // Every-cycle comparison of all outputs of all instances.
   always @(negedge vga_clk) begin
      logic [43:0] e, a;
      if (started) begin
         for (int k = 0; k < 3; k++) begin
            e = expv(k);
            a = {a_dx[k], a_dy[k], a_bl[k], a_hs[k], a_vs[k], a_hsd[k], a_vsd[k], a_bld[k],
                 a_ls[k], a_fs[k], a_fc[k]};
            n_vec++;
            if (a !== e) begin
               n_fail++;
               $display("FAIL cycle_dut%0d t=%0d got %h want %h", k, t[k], a, e);
            end
         end
      end
   end

   task automatic chk(string nm, longint act, longint exp);
      n_vec++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s got %0d want %0d", nm, act, exp);
      end
   endtask

   initial begin
      int hs_cnt, hs_first, bl_late, spacing, vs_cnt, vs_first, bl_bad;
      reset_n = 1'b0;
      repeat (5) @(negedge vga_clk);
      chk("rst_x", a_dx[0], 0);
      chk("rst_y", a_dy[0], 0);
      chk("rst_blank", a_bl[0], 0);
      chk("rst_hs", a_hs[0], 1);
      chk("rst_vs", a_vs[0], 1);
      chk("rst_fc", a_fc[0], 0);
      chk("rst_blank_d", a_bld[0], 0);

      reset_n = 1'b1;
      @(negedge vga_clk);
      chk("run0_x", a_dx[0], 0);
      chk("run0_y", a_dy[0], 0);
      chk("run0_blank", a_bl[0], 1);
      chk("run0_fs", a_fs[0], 1);
      chk("run0_ls", a_ls[0], 1);
      @(negedge vga_clk);
      chk("run1_x", a_dx[0], 1);
      chk("run1_fs", a_fs[0], 0);
      chk("run1_blank_d", a_bld[0], 0);
      @(negedge vga_clk);
      chk("run2_blank_d", a_bld[0], 1);

      // Line 0 of the default raster: hsync window and right-side blanking.
      hs_cnt = 0; hs_first = -1; bl_late = 0;
      for (int i = 0; i < 1000 && a_dx[0] != 10'd799; i++) begin
         if (!a_hs[0]) begin
            hs_cnt++;
            if (hs_first < 0) hs_first = int'(a_dx[0]);
         end
         if (a_dx[0] >= 10'd640 && a_bl[0]) bl_late++;
         @(negedge vga_clk);
      end
      if (!a_hs[0]) hs_cnt++;
      if (a_bl[0]) bl_late++;
      chk("line0_last_x", a_dx[0], 799);
      chk("hs_low_width", hs_cnt, 96);
      chk("hs_low_start", hs_first, 656);
      chk("blank_right_porch", bl_late, 0);
      @(negedge vga_clk);
      chk("wrap_x", a_dx[0], 0);
      chk("wrap_y", a_dy[0], 1);
      chk("wrap_ls", a_ls[0], 1);
      chk("line1_blank_d_t0", a_bld[0], 0);
      @(negedge vga_clk);
      chk("line1_blank_d_t1", a_bld[0], 0);
      @(negedge vga_clk);
      chk("line1_blank_d_t2", a_bld[0], 1);

      // Short-frame instance: vsync width, vertical blanking, frame spacing.
      for (int i = 0; i < 20000 && !a_fs[1]; i++) @(negedge vga_clk);
      chk("fs1_first_seen", a_fs[1], 1);
      chk("fc1_after_wrap1", a_fc[1], 1);
      spacing = 0; vs_cnt = 0; vs_first = -1; bl_bad = 0;
      do begin
         if (!a_vs[1]) begin
            vs_cnt++;
            if (vs_first < 0) vs_first = int'(a_dy[1]);
         end
         if (a_dy[1] >= 10'd12 && a_bl[1]) bl_bad++;
         @(negedge vga_clk);
         spacing++;
      end while (!a_fs[1] && spacing < 20000);
      chk("frame_spacing", spacing, 15200);
      chk("vs_low_cycles", vs_cnt, 1600);
      chk("vs_first_line", vs_first, 14);
      chk("vblank_lines", bl_bad, 0);
      chk("fc1_after_wrap2", a_fc[1], 2);
      @(negedge vga_clk);
      for (int i = 0; i < 20000 && !a_fs[1]; i++) @(negedge vga_clk);
      chk("fc1_after_wrap3", a_fc[1], 3);

      // Mid-frame reset.
      for (int i = 0; i < 20000 && !(a_dx[1] == 10'd300 && a_dy[1] == 10'd10); i++)
         @(negedge vga_clk);
      chk("pre_rst_x", a_dx[1], 300);
      chk("pre_rst_blank_d0", a_bld[0], 1);
      reset_n = 1'b0;
      @(negedge vga_clk);
      chk("mid_rst_x", a_dx[1], 0);
      chk("mid_rst_y", a_dy[1], 0);
      chk("mid_rst_fc", a_fc[1], 0);
      chk("mid_rst_blank", a_bl[1], 0);
      chk("mid_rst_hs_d0", a_hsd[0], 1);
      chk("mid_rst_blank_d0", a_bld[0], 0);
      reset_n = 1'b1;
      @(negedge vga_clk);
      chk("restart_x", a_dx[0], 0);
      chk("restart_y", a_dy[0], 0);
      chk("restart_blank", a_bl[0], 1);
      chk("restart_fc", a_fc[1], 0);
      chk("restart_hs_d", a_hsd[0], 1);
      chk("restart_vs_d", a_vsd[0], 1);
      chk("restart_blank_d", a_bld[0], 0);

      // Frame counter rollover on the tiny raster (40 cycles per frame).
      repeat (7) @(negedge vga_clk);
      #2;
      force dut2.r_frame_count = 16'hFFFE;
      fcoff[2] = 16'hFFFE - int'(t[2] / 40);
      #1;
      release dut2.r_frame_count;
      repeat (40) @(negedge vga_clk);
      chk("fc2_ffff", a_fc[2], 16'hFFFF);
      repeat (40) @(negedge vga_clk);
      chk("fc2_rollover", a_fc[2], 0);
      repeat (10) @(negedge vga_clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
